// File: rtl/acq_sched_defs.sv
// Shared definitions for the radar frame acquisition scheduler: FSM states, header magic, word layout.
// Optional build macro ACQ_SCHED_TEST_PATTERN_EN is consumed by acq_frame_scheduler.
package acq_sched_defs;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_CHIRP = 2'd1,
        ST_ACQ        = 2'd2,
        ST_NEXT       = 2'd3
    } state_e;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    localparam int IDX_W = 5;
    localparam int FRM_W = 16;
    localparam int CNT_W = 13;
    localparam int SMP_W = 13;

    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_IDX_LSB   = 16;
    localparam int HDR_FRM_LSB   = 0;
    localparam int SMP_IDX_LSB   = 26;
    localparam int SMP_CNT_LSB   = 13;
    localparam int SMP_DAT_LSB   = 0;

    function automatic logic [31:0] hdr_word(input logic [IDX_W-1:0] idx,
                                             input logic [FRM_W-1:0] frm);
        logic [31:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 8]   = HDR_MAGIC;
        w[HDR_IDX_LSB +: IDX_W] = idx;
        w[HDR_FRM_LSB +: FRM_W] = frm;
        return w;
    endfunction

    // Bit 31 stays 0 so sample words can never alias the 0xA5 header magic.
    function automatic logic [31:0] smp_word(input logic [IDX_W-1:0] idx,
                                             input logic [CNT_W-1:0] cnt,
                                             input logic [SMP_W-1:0] dat);
        logic [31:0] w;
        w = '0;
        w[SMP_IDX_LSB +: IDX_W] = idx;
        w[SMP_CNT_LSB +: CNT_W] = cnt;
        w[SMP_DAT_LSB +: SMP_W] = dat;
        return w;
    endfunction

endpackage

// File: rtl/acq_pkt_pacer.sv
// Counts FIFO words into UDP payloads and paces tx_start pulses with a minimum holdoff.
// Latency: tx_start_o is combinational on the pending count; it waits while tx_busy_i or holdoff is active.
module acq_pkt_pacer #(
    parameter int WORDS_PER_PKT  = 34,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic word_wr_i,
    input  logic tx_busy_i,
    output logic tx_start_o
);
    localparam int WC_W = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
    localparam int HO_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_PKT - 1);
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYCLES);

    logic [WC_W-1:0] word_cnt_q, word_cnt_d;
    logic [7:0]      pkt_pend_q, pkt_pend_d;
    logic [HO_W-1:0] holdoff_q, holdoff_d;
    logic            pkt_inc;
    logic            fire;

    assign fire       = (pkt_pend_q != 8'd0) && !tx_busy_i && (holdoff_q == '0);
    assign tx_start_o = fire;

    always_comb begin
        word_cnt_d = word_cnt_q;
        pkt_inc    = 1'b0;
        if (word_wr_i) begin
            if (word_cnt_q == WC_LAST) begin
                word_cnt_d = '0;
                pkt_inc    = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + WC_W'(1);
            end
        end

        pkt_pend_d = pkt_pend_q;
        if (pkt_inc && !fire && (pkt_pend_q != 8'hFF)) begin
            pkt_pend_d = pkt_pend_q + 8'd1;
        end else if (fire && !pkt_inc) begin
            pkt_pend_d = pkt_pend_q - 8'd1;
        end

        holdoff_d = holdoff_q;
        if (fire) begin
            holdoff_d = HO_LOAD;
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - HO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            pkt_pend_q <= '0;
            holdoff_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            pkt_pend_q <= pkt_pend_d;
            holdoff_q  <= holdoff_d;
        end
    end

endmodule

// File: rtl/acq_frame_scheduler.sv
// Sequences one radar frame: chirp-gated sample capture, header/sample word formatting, FIFO writes.
// Writes land 1 cycle after the accepting event; fifo_full_i drops the word (sticky overflow_o).
// Build macro ACQ_SCHED_TEST_PATTERN_EN replaces sample_i with an internal ramp counter.
module acq_frame_scheduler
    import acq_sched_defs::*;
#(
    parameter int SAMPLES_PER_CHIRP = 256,
    parameter int WORDS_PER_PKT     = 34,
    parameter int HOLDOFF_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm_i,
    input  logic        chirp_start_i,
    input  logic [4:0]  chirp_num_i,
    input  logic        sample_valid_i,
    input  logic [12:0] sample_i,
    input  logic        fifo_full_i,
    input  logic        tx_busy_i,
    output logic        ad_en_o,
    output logic        fifo_wr_en_o,
    output logic [31:0] fifo_din_o,
    output logic        tx_start_o,
    output logic        frame_done_o,
    output logic        overflow_o,
    output logic        chirp_miss_o
);
    localparam logic [CNT_W-1:0] SPC_LAST = CNT_W'(SAMPLES_PER_CHIRP - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   chirp_idx_q, chirp_idx_d;
    logic [FRM_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic               ad_en_q, ad_en_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        din_q, din_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;
    logic               chirp_miss_q, chirp_miss_d;

    logic               wr_req;
    logic [31:0]        wr_word;
    logic [IDX_W-1:0]   last_idx;
    logic               smp_take;
    logic [SMP_W-1:0]   smp_src;

    assign last_idx = (chirp_num_i == 5'd0) ? 5'd0 : (chirp_num_i - 5'd1);
    assign smp_take = (state_q == ST_ACQ) && sample_valid_i;

`ifdef ACQ_SCHED_TEST_PATTERN_EN
    // Ramp runs across chirps and frames so dropped or misplaced samples show up as gaps.
    logic [SMP_W-1:0] tp_cnt_q, tp_cnt_d;

    always_comb begin
        tp_cnt_d = tp_cnt_q;
        if (smp_take) begin
            tp_cnt_d = tp_cnt_q + SMP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_cnt_q <= '0;
        end else begin
            tp_cnt_q <= tp_cnt_d;
        end
    end

    assign smp_src = tp_cnt_q;
`else
    assign smp_src = sample_i;
`endif

    always_comb begin
        state_d      = state_q;
        chirp_idx_d  = chirp_idx_q;
        frame_cnt_d  = frame_cnt_q;
        sample_cnt_d = sample_cnt_q;
        wr_en_d      = 1'b0;
        din_d        = din_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        chirp_miss_d = chirp_miss_q;
        ad_en_d      = (state_q == ST_ACQ) && !fifo_full_i;
        wr_req       = 1'b0;
        wr_word      = '0;

        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    state_d = ST_WAIT_CHIRP;
                end
            end
            ST_WAIT_CHIRP: begin
                if (!arm_i) begin
                    state_d = ST_IDLE;
                end else if (chirp_start_i) begin
                    state_d      = ST_ACQ;
                    sample_cnt_d = '0;
                    wr_req       = 1'b1;
                    wr_word      = hdr_word(chirp_idx_q, frame_cnt_q);
                end
            end
            ST_ACQ: begin
                if (chirp_start_i) begin
                    chirp_miss_d = 1'b1;
                end
                if (sample_valid_i) begin
                    wr_req  = 1'b1;
                    wr_word = smp_word(chirp_idx_q, sample_cnt_q, smp_src);
                    if (sample_cnt_q == SPC_LAST) begin
                        sample_cnt_d = '0;
                        state_d      = ST_NEXT;
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_NEXT: begin
                // >= guards against chirp_num_i being lowered mid-frame.
                if (chirp_idx_q >= last_idx) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    chirp_idx_d  = '0;
                end else begin
                    chirp_idx_d = chirp_idx_q + 5'd1;
                end
                state_d = arm_i ? ST_WAIT_CHIRP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_req) begin
            if (fifo_full_i) begin
                overflow_d = 1'b1;
            end else begin
                wr_en_d = 1'b1;
                din_d   = wr_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            chirp_idx_q  <= '0;
            frame_cnt_q  <= '0;
            sample_cnt_q <= '0;
            ad_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            din_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            chirp_miss_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            chirp_idx_q  <= chirp_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            ad_en_q      <= ad_en_d;
            wr_en_q      <= wr_en_d;
            din_q        <= din_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            chirp_miss_q <= chirp_miss_d;
        end
    end

    acq_pkt_pacer #(
        .WORDS_PER_PKT  (WORDS_PER_PKT),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_pacer (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_wr_i  (wr_en_q),
        .tx_busy_i  (tx_busy_i),
        .tx_start_o (tx_start_o)
    );

    assign ad_en_o      = ad_en_q;
    assign fifo_wr_en_o = wr_en_q;
    assign fifo_din_o   = din_q;
    assign frame_done_o = frame_done_q;
    assign overflow_o   = overflow_q;
    assign chirp_miss_o = chirp_miss_q;

endmodule

// File: tb/tb_acq_frame_scheduler.sv
// Directed bench for acq_frame_scheduler with 4 samples per chirp and 34-word packets.
module tb_acq_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm_i;
    logic        chirp_start_i;
    logic [4:0]  chirp_num_i;
    logic        sample_valid_i;
    logic [12:0] sample_i;
    logic        fifo_full_i;
    logic        tx_busy_i;
    logic        ad_en_o;
    logic        fifo_wr_en_o;
    logic [31:0] fifo_din_o;
    logic        tx_start_o;
    logic        frame_done_o;
    logic        overflow_o;
    logic        chirp_miss_o;

    always #5 clk = ~clk;

    acq_frame_scheduler #(
        .SAMPLES_PER_CHIRP (4),
        .WORDS_PER_PKT     (34),
        .HOLDOFF_CYCLES    (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .arm_i          (arm_i),
        .chirp_start_i  (chirp_start_i),
        .chirp_num_i    (chirp_num_i),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .fifo_full_i    (fifo_full_i),
        .tx_busy_i      (tx_busy_i),
        .ad_en_o        (ad_en_o),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_din_o     (fifo_din_o),
        .tx_start_o     (tx_start_o),
        .frame_done_o   (frame_done_o),
        .overflow_o     (overflow_o),
        .chirp_miss_o   (chirp_miss_o)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          fd_cnt   = 0;
    int          tx_cnt   = 0;
    int          tx_t[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          got_base;
    int          tp_exp;
    int          fd0;
    int          tx0;

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_wr_en_o) got_q.push_back(fifo_din_o);
        if (frame_done_o) fd_cnt <= fd_cnt + 1;
        if (tx_start_o) begin
            tx_cnt <= tx_cnt + 1;
            tx_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input int idx, input int frm);
        return {8'hA5, 3'b000, 5'(idx), 16'(frm)};
    endfunction

    function automatic logic [31:0] smp(input int idx, input int cnt, input int val);
        return {1'b0, 5'(idx), 13'(cnt), 13'(val)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chirp();
        chirp_start_i = 1'b1;
        step();
        chirp_start_i = 1'b0;
    endtask

    // mode 0: written, 1: dropped by fifo_full_i, 2: ignored (not in ACQ)
    task automatic send_sample(input int idx, input int cnt, input int raw, input int mode);
        int v;
`ifdef ACQ_SCHED_TEST_PATTERN_EN
        v = tp_exp;
`else
        v = raw;
`endif
        sample_i       = 13'(raw);
        sample_valid_i = 1'b1;
        fifo_full_i    = (mode == 1);
        step();
        sample_valid_i = 1'b0;
        fifo_full_i    = 1'b0;
        if (mode == 1) check("ad_en_low_on_full", 32'(ad_en_o), 32'd0);
        if (mode == 0) exp_q.push_back(smp(idx, cnt, v));
        if (mode != 2) tp_exp++;
        step();
    endtask

    task automatic mark();
        got_base = got_q.size();
        exp_q.delete();
    endtask

    task automatic compare_q(input string tag);
        int n;
        n = got_q.size() - got_base;
        check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s_w%0d", tag, i), got_q[got_base + i], exp_q[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        tp_exp = 0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; arm_i = 1'b0; chirp_start_i = 1'b0; chirp_num_i = 5'd0;
        sample_valid_i = 1'b0; sample_i = 13'd0; fifo_full_i = 1'b0; tx_busy_i = 1'b0;
        tp_exp = 0;
        repeat (3) step();
        check("rst_ad_en",      32'(ad_en_o),      32'd0);
        check("rst_wr_en",      32'(fifo_wr_en_o), 32'd0);
        check("rst_din",        fifo_din_o,        32'd0);
        check("rst_tx_start",   32'(tx_start_o),   32'd0);
        check("rst_frame_done", 32'(frame_done_o), 32'd0);
        check("rst_overflow",   32'(overflow_o),   32'd0);
        check("rst_chirp_miss", 32'(chirp_miss_o), 32'd0);
        rst_n = 1'b1;
        step();

        // Frame 0: two chirps, four samples each
        chirp_num_i = 5'd2; arm_i = 1'b1;
        step(); step();
        mark(); fd0 = fd_cnt;
        exp_q.push_back(hdr(0, 0)); send_chirp();
        send_sample(0, 0, 100, 0);
        check("t1_ad_en_acq", 32'(ad_en_o), 32'd1);
        send_sample(0, 1, 101, 0); send_sample(0, 2, 102, 0); send_sample(0, 3, 103, 0);
        exp_q.push_back(hdr(1, 0)); send_chirp();
        for (int s = 0; s < 4; s++) send_sample(1, s, 200 + s, 0);
        repeat (3) step();
        compare_q("t1");
        check("t1_frame_done", 32'(fd_cnt - fd0), 32'd1);
        check("t1_ad_en_wait", 32'(ad_en_o),      32'd0);
        check("t1_overflow",   32'(overflow_o),   32'd0);
        check("t1_chirp_miss", 32'(chirp_miss_o), 32'd0);

        // Frame 1: sample 2 dropped on full, stray chirp strobe during ACQ
        mark(); fd0 = fd_cnt;
        exp_q.push_back(hdr(0, 1)); send_chirp();
        send_sample(0, 0, 300, 0); send_sample(0, 1, 301, 0);
        send_chirp();
        send_sample(0, 2, 302, 1); send_sample(0, 3, 303, 0);
        exp_q.push_back(hdr(1, 1)); send_chirp();
        for (int s = 0; s < 4; s++) send_sample(1, s, 400 + s, 0);
        repeat (3) step();
        compare_q("t2");
        check("t2_overflow",   32'(overflow_o),     32'd1);
        check("t3_chirp_miss", 32'(chirp_miss_o),   32'd1);
        check("t2_frame_done", 32'(fd_cnt - fd0),   32'd1);

        // Frame 2: disarm mid-chirp, chirp finishes, then idle ignores strobes
        mark(); fd0 = fd_cnt;
        exp_q.push_back(hdr(0, 2)); send_chirp();
        send_sample(0, 0, 500, 0);
        arm_i = 1'b0;
        send_sample(0, 1, 501, 0); send_sample(0, 2, 502, 0); send_sample(0, 3, 503, 0);
        step(); step();
        send_chirp();
        send_sample(0, 0, 504, 2);
        step(); step();
        compare_q("t5");
        check("t5_frame_done", 32'(fd_cnt - fd0), 32'd0);
        check("t5_ad_en",      32'(ad_en_o),      32'd0);

        // Re-arm resumes at chirp 1 of frame 2; async reset mid-ACQ
        arm_i = 1'b1;
        step(); step();
        mark();
        exp_q.push_back(hdr(1, 2)); send_chirp();
        sample_i = 13'd600; sample_valid_i = 1'b1;
        step();
        sample_valid_i = 1'b0;
        check("t6_pre_wr_en", 32'(fifo_wr_en_o), 32'd1);
        check("t6_pre_ad_en", 32'(ad_en_o),      32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_wr_en",      32'(fifo_wr_en_o), 32'd0);
        check("t6_async_din",        fifo_din_o,        32'd0);
        check("t6_async_ad_en",      32'(ad_en_o),      32'd0);
        check("t6_async_overflow",   32'(overflow_o),   32'd0);
        check("t6_async_chirp_miss", 32'(chirp_miss_o), 32'd0);
        check("t6_async_frame_done", 32'(frame_done_o), 32'd0);
        compare_q("t6_hdr");
        step();
        rst_n  = 1'b1;
        tp_exp = 0;
        step(); step();
        mark();
        exp_q.push_back(hdr(0, 0)); send_chirp();
        send_sample(0, 0, 700, 0); send_sample(0, 1, 710, 0);
        send_sample(0, 2, 720, 0); send_sample(0, 3, 730, 0);
        step(); step();
        compare_q("t6_post");

        // Packet pacing: chirp_num 0 acts as 1, 70 words -> 2 packets held by tx_busy_i
        do_reset();
        chirp_num_i = 5'd0; tx_busy_i = 1'b1; arm_i = 1'b1;
        step(); step();
        mark(); fd0 = fd_cnt; tx0 = tx_cnt;
        for (int c = 0; c < 14; c++) begin
            exp_q.push_back(hdr(0, c)); send_chirp();
            for (int s = 0; s < 4; s++) send_sample(0, s, c * 16 + s, 0);
            step();
        end
        step(); step();
        compare_q("t4");
        check("t4_frame_done", 32'(fd_cnt - fd0), 32'd14);
        check("t4_busy_no_tx", 32'(tx_cnt - tx0), 32'd0);
        tx_busy_i = 1'b0;
        repeat (60) step();
        check("t4_tx_count", 32'(tx_cnt - tx0), 32'd2);
        if (tx_t.size() >= tx0 + 2)
            check("t4_tx_gap_ge16", 32'((tx_t[tx0 + 1] - tx_t[tx0]) >= 16), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
